cache_sa_wt: RTL

// Parametrised N-way set-associative, write-through, no-write-allocate cache for the pipelined CPU.

---
 rtl/cache_sa_wt_pkg.sv | 28 ++
 rtl/cache_sa_wt_if.sv | 40 ++++
 rtl/cache_sa_wt_way.sv | 56 +++++
 rtl/cache_sa_wt.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cache_sa_wt_pkg.sv
// Shared definitions for the set-associative write-through cache:
// controller state encoding and default geometry.
package cache_sa_wt_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TAG      = 3'd1,
        S_MEM_RD   = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_MEM_WR   = 3'd4
    } state_e;

    localparam int DEF_ADDRESS_BITS = 32;
    localparam int DEF_INDEX_BITS   = 6;
    localparam int DEF_OFFSET_BITS  = 3;
    localparam int DEF_WAYS         = 2;
    localparam int DEF_SETS         = 2 ** DEF_INDEX_BITS;
    localparam int DEF_WORDS        = 2 ** DEF_OFFSET_BITS;
    localparam int DEF_TAG_BITS     = DEF_ADDRESS_BITS - DEF_INDEX_BITS - DEF_OFFSET_BITS;

    // Width of a way number; a direct-mapped cache still carries one bit.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    localparam int DEF_WAY_BITS = way_bits(DEF_WAYS);

endpackage

// File: rtl/cache_sa_wt_if.sv
// CPU-side and next-level-side handshake buses of the cache.
// slave = the cache's view, master = the surrounding system's view.
interface cache_sa_wt_if #(
    parameter int ADDRESS_BITS = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_BITS  = 3
);
    localparam int LINE_W = (2 ** OFFSET_BITS) * DATA_WIDTH;

    logic                    cpu_req_valid;
    logic                    cpu_req_write;
    logic [ADDRESS_BITS-1:0] cpu_req_addr;
    logic [DATA_WIDTH-1:0]   cpu_req_wdata;
    logic                    cpu_req_ready;
    logic                    cpu_resp_valid;
    logic [DATA_WIDTH-1:0]   cpu_resp_rdata;

    logic                    mem_req_valid;
    logic                    mem_req_write;
    logic [ADDRESS_BITS-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0]   mem_req_wdata;
    logic                    mem_req_ready;
    logic                    mem_resp_valid;
    logic [LINE_W-1:0]       mem_resp_data;

    modport slave (
        input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/cache_sa_wt_way.sv
// One way of the cache: valid/tag/data storage per set with a lookup port,
// a single-word write port and a whole-line fill port.
module cache_sa_wt_way
    import cache_sa_wt_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 3,
    parameter int TAG_BITS    = 23
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,
    input  logic [INDEX_BITS-1:0]                 idx_i,
    input  logic [OFFSET_BITS-1:0]                off_i,
    input  logic [TAG_BITS-1:0]                   tag_i,
    output logic                                  hit_o,
    output logic                                  valid_o,
    output logic [DATA_WIDTH-1:0]                 word_o,
    input  logic                                  wr_en_i,
    input  logic [DATA_WIDTH-1:0]                 wr_data_i,
    input  logic                                  fill_en_i,
    input  logic [(2**OFFSET_BITS)*DATA_WIDTH-1:0] fill_line_i
);
    localparam int SETS  = 2 ** INDEX_BITS;
    localparam int WORDS = 2 ** OFFSET_BITS;

    logic [SETS-1:0]       valid_q;
    logic [TAG_BITS-1:0]   tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][WORDS];

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[idx_i] <= tag_i;
            for (int i = 0; i < WORDS; i++) begin
                data_q[idx_i][i] <= fill_line_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (wr_en_i) begin
            data_q[idx_i][off_i] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    assign word_o  = data_q[idx_i][off_i];

endmodule

// File: rtl/cache_sa_wt.sv
// N-way set-associative, write-through, no-write-allocate cache with line
// refill, round-robin replacement, flush and saturating hit/miss counters.
module cache_sa_wt
    import cache_sa_wt_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int INDEX_BITS   = 6,
    parameter int OFFSET_BITS  = 3,
    parameter int WAYS         = 2,
    parameter int CNT_BITS     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    cache_sa_wt_if.slave        bus,
    output logic [CNT_BITS-1:0] hit_count_o,
    output logic [CNT_BITS-1:0] miss_count_o
);
    localparam int SETS     = 2 ** INDEX_BITS;
    localparam int TAG_BITS = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_BITS = way_bits(WAYS);

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_BITS'(1);
    endfunction

    state_e                  state_q, state_d;
    logic                    req_write_q;
    logic [ADDRESS_BITS-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0]   req_wdata_q;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CNT_BITS-1:0]     hit_cnt_q, miss_cnt_q;
    logic [WAY_BITS-1:0]     rr_q [SETS];

    logic                    accept, clear_all, fill_en, wr_hit_en;
    logic                    mem_valid, mem_write;
    logic [WAYS-1:0]         hit_vec, valid_vec;
    logic [DATA_WIDTH-1:0]   way_word [WAYS];
    logic [DATA_WIDTH-1:0]   hit_word, fill_word;
    logic [WAY_BITS-1:0]     victim;
    logic                    all_valid;

    logic [TAG_BITS-1:0]     tag;
    logic [INDEX_BITS-1:0]   idx;
    logic [OFFSET_BITS-1:0]  off;

    assign tag = req_addr_q[ADDRESS_BITS-1 -: TAG_BITS];
    assign idx = req_addr_q[OFFSET_BITS +: INDEX_BITS];
    assign off = req_addr_q[OFFSET_BITS-1:0];

    assign accept    = (state_q == S_IDLE) && !flush_i && bus.cpu_req_valid;
    assign clear_all = (state_q == S_IDLE) && flush_i;
    assign wr_hit_en = (state_q == S_TAG) && req_write_q;
    assign fill_en   = (state_q == S_MEM_WAIT) && bus.mem_resp_valid;
    assign fill_word = bus.mem_resp_data[off*DATA_WIDTH +: DATA_WIDTH];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_sa_wt_way #(
            .DATA_WIDTH (DATA_WIDTH),
            .INDEX_BITS (INDEX_BITS),
            .OFFSET_BITS(OFFSET_BITS),
            .TAG_BITS   (TAG_BITS)
        ) u_way (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clear_i    (clear_all),
            .idx_i      (idx),
            .off_i      (off),
            .tag_i      (tag),
            .hit_o      (hit_vec[w]),
            .valid_o    (valid_vec[w]),
            .word_o     (way_word[w]),
            .wr_en_i    (wr_hit_en && hit_vec[w]),
            .wr_data_i  (req_wdata_q),
            .fill_en_i  (fill_en && (victim == WAY_BITS'(w))),
            .fill_line_i(bus.mem_resp_data)
        );
    end

    // Lowest-numbered invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        all_valid = &valid_vec;
        victim    = rr_q[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) victim = WAY_BITS'(w);
        end
    end

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_word = way_word[w];
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        mem_valid    = 1'b0;
        mem_write    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_TAG;
            end
            S_TAG: begin
                if (req_write_q) begin
                    state_d = S_MEM_WR;
                end else if (|hit_vec) begin
                    resp_valid_d = 1'b1;
                    rdata_d      = hit_word;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_valid = 1'b1;
                if (bus.mem_req_ready) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (bus.mem_resp_valid) begin
                    resp_valid_d = 1'b1;
                    rdata_d      = fill_word;
                    state_d      = S_IDLE;
                end
            end
            S_MEM_WR: begin
                mem_valid = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_req_ready) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
        if (accept) begin
            req_write_q <= bus.cpu_req_write;
            req_addr_q  <= bus.cpu_req_addr;
            req_wdata_q <= bus.cpu_req_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_TAG) begin
            if (|hit_vec) hit_cnt_q  <= sat_inc(hit_cnt_q);
            else          miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end

    // The pointer only advances when a fill displaces a valid line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (fill_en && all_valid && (WAYS > 1)) begin
            rr_q[idx] <= rr_q[idx] + WAY_BITS'(1);
        end
    end

    assign bus.cpu_req_ready  = (state_q == S_IDLE) && !flush_i;
    assign bus.cpu_resp_valid = resp_valid_q;
    assign bus.cpu_resp_rdata = resp_valid_q ? rdata_q : '0;
    assign bus.mem_req_valid  = mem_valid;
    assign bus.mem_req_write  = mem_write;
    assign bus.mem_req_addr   = !mem_valid ? '0 :
                                mem_write  ? req_addr_q :
                                {req_addr_q[ADDRESS_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign bus.mem_req_wdata  = mem_write ? req_wdata_q : '0;
    assign hit_count_o        = hit_cnt_q;
    assign miss_count_o       = miss_cnt_q;

endmodule
